// File: rtl/bin_to_bcd_serial_pkg.sv
// Shared constants and helpers for the serial binary-to-BCD converter and
// the HEX display path that consumes its digits.
package bin_to_bcd_serial_pkg;

  localparam int         DIGIT_W     = 4;
  localparam logic [3:0] ADD3_THRESH = 4'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } conv_state_e;

  function automatic longint unsigned pow10(input int n);
    longint unsigned p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

endpackage

// File: rtl/bin_to_bcd_serial_add3.sv
// One BCD digit's double-dabble correction: digits of 5 or more get +3 so
// the following left shift carries cleanly into the next decade.
module bcd_add3_digit
  import bin_to_bcd_serial_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout
);

  assign dout = (din >= ADD3_THRESH) ? din + 4'd3 : din;

endmodule

// File: rtl/bin_to_bcd_serial.sv
// Iterative shift-and-add-3 binary-to-BCD converter, one bit per clock, with
// start/busy/done handshake and a leading-zero blank mask for the HEX displays.
module bin_to_bcd_serial
  import bin_to_bcd_serial_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [BIN_W-1:0]          bin_in,
  output logic                      busy,
  output logic                      done,
  output logic [DIGIT_W*DIGITS-1:0] bcd_out,
  output logic [DIGITS-1:0]         digit_blank
);

  localparam int                CNT_W     = $clog2(BIN_W + 1);
  localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

  if (BIN_W < 4) begin : g_bad_width
    $error("bin_to_bcd_serial: BIN_W must be at least 4");
  end
  if (pow10(DIGITS) <= ((longint'(1) << BIN_W) - 1)) begin : g_bad_digits
    $error("bin_to_bcd_serial: DIGITS too small for BIN_W");
  end

  conv_state_e               state;
  logic [BIN_W-1:0]          shift_reg, shift_nxt;
  logic [DIGIT_W*DIGITS-1:0] scratch, adj, scratch_nxt;
  logic [CNT_W-1:0]          cnt;
  logic [DIGITS-1:0]         blank_nxt;

  for (genvar d = 0; d < DIGITS; d++) begin : g_digit
    bcd_add3_digit u_add3 (
      .din  (scratch[DIGIT_W*d +: DIGIT_W]),
      .dout (adj[DIGIT_W*d +: DIGIT_W])
    );
  end

  assign {scratch_nxt, shift_nxt} = {adj, shift_reg} << 1;

  // Blank a digit only when it and every digit above it are zero; ones never blank.
  always_comb begin
    blank_nxt = '0;
    blank_nxt[DIGITS-1] = (scratch_nxt[DIGIT_W*(DIGITS-1) +: DIGIT_W] == '0);
    for (int i = DIGITS - 2; i >= 1; i--)
      blank_nxt[i] = blank_nxt[i+1] & (scratch_nxt[DIGIT_W*i +: DIGIT_W] == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      bcd_out     <= '0;
      digit_blank <= BLANK_RST;
      scratch     <= '0;
      shift_reg   <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          if (start) begin
            shift_reg <= bin_in;
            scratch   <= '0;
            cnt       <= CNT_W'(BIN_W);
            busy      <= 1'b1;
            state     <= ST_SHIFT;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          scratch   <= scratch_nxt;
          shift_reg <= shift_nxt;
          cnt       <= cnt - 1'b1;
          // Last shift publishes the result straight from the shifted scratch.
          if (cnt == CNT_W'(1)) begin
            busy        <= 1'b0;
            done        <= 1'b1;
            bcd_out     <= scratch_nxt;
            digit_blank <= blank_nxt;
            state       <= ST_DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
